// File: rtl/matmul_pkg.sv
// ============================================================================
// Module   : matmul_pkg
// Purpose  : Shared widths, FSM states and operand ordering for the
//            matrix-multiply datapath (demux and MAC engine).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package matmul_pkg;

    localparam int c_DW    = 16;
    localparam int c_OUT_W = 2 * c_DW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC0 = 2'd1,
        MAC1 = 2'd2,
        OUT  = 2'd3
    } state_t;

    localparam int         c_NUM_ELEM = 6;
    localparam logic [2:0] c_LAST_IDX = 3'(c_NUM_ELEM - 1);
    localparam int         c_NUM_OPS  = 10;

    // Operand slots in demux output order: A row-major, then B row-major.
    localparam logic [3:0] c_IDX_A00 = 4'd0;
    localparam logic [3:0] c_IDX_A01 = 4'd1;
    localparam logic [3:0] c_IDX_A10 = 4'd2;
    localparam logic [3:0] c_IDX_A11 = 4'd3;
    localparam logic [3:0] c_IDX_B00 = 4'd4;
    localparam logic [3:0] c_IDX_B01 = 4'd5;
    localparam logic [3:0] c_IDX_B02 = 4'd6;
    localparam logic [3:0] c_IDX_B10 = 4'd7;
    localparam logic [3:0] c_IDX_B11 = 4'd8;
    localparam logic [3:0] c_IDX_B12 = 4'd9;

endpackage

`default_nettype wire

// File: rtl/mac16.sv
// ============================================================================
// Module   : mac16
// Purpose  : Registered multiply-add with clear; signed when MATMUL_SIGNED_EN
//            is defined, unsigned otherwise.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac16 #(
    parameter int DW    = 16,
    parameter int OUT_W = 2 * DW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DW-1:0]    x,
    input  logic [DW-1:0]    y,
    input  logic             clr,
    input  logic             en,
    output logic [OUT_W-1:0] acc
);

    logic [2*DW-1:0]  w_prod;
    logic [OUT_W-1:0] w_prod_ext;
    logic [OUT_W-1:0] r_acc;

`ifdef MATMUL_SIGNED_EN
    assign w_prod     = $signed({{DW{x[DW-1]}}, x}) * $signed({{DW{y[DW-1]}}, y});
    assign w_prod_ext = {{(OUT_W - 2*DW){w_prod[2*DW-1]}}, w_prod};
`else
    assign w_prod     = {{DW{1'b0}}, x} * {{DW{1'b0}}, y};
    assign w_prod_ext = {{(OUT_W - 2*DW){1'b0}}, w_prod};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (en) begin
            r_acc <= clr ? w_prod_ext : (r_acc + w_prod_ext);
        end
    end

    assign acc = r_acc;

endmodule

`default_nettype wire

// File: rtl/matmul_2x3_mac.sv
// ============================================================================
// Module   : matmul_2x3_mac
// Purpose  : C = A(2x2) * B(2x3) with one multiplier, streamed out row-major
//            over valid/ready. Build macro: MATMUL_SIGNED_EN (signed math).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module matmul_2x3_mac
    import matmul_pkg::*;
#(
    parameter int DW    = c_DW,
    parameter int OUT_W = 2 * DW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DW-1:0]    a0,
    input  logic [DW-1:0]    a1,
    input  logic [DW-1:0]    a2,
    input  logic [DW-1:0]    a3,
    input  logic [DW-1:0]    b0,
    input  logic [DW-1:0]    b1,
    input  logic [DW-1:0]    b2,
    input  logic [DW-1:0]    b3,
    input  logic [DW-1:0]    b4,
    input  logic [DW-1:0]    b5,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [2:0]       out_idx,
    output logic             done
);

    state_t          r_state;
    logic [DW-1:0]   r_op [c_NUM_OPS];
    logic            r_i;
    logic [1:0]      r_j;
    logic [2:0]      r_idx;
    logic            r_busy;
    logic            r_valid;
    logic            r_done;

    logic [DW-1:0]   w_x;
    logic [DW-1:0]   w_y;
    logic [DW-1:0]   w_b0j;
    logic [DW-1:0]   w_b1j;
    logic            w_en;
    logic            w_clr;

    // Column select of B for the current element.
    always_comb begin
        w_b0j = r_op[c_IDX_B00];
        w_b1j = r_op[c_IDX_B10];
        case (r_j)
            2'd1: begin
                w_b0j = r_op[c_IDX_B01];
                w_b1j = r_op[c_IDX_B11];
            end
            2'd2: begin
                w_b0j = r_op[c_IDX_B02];
                w_b1j = r_op[c_IDX_B12];
            end
            default: ;
        endcase
    end

    assign w_clr = (r_state == MAC0);
    assign w_en  = (r_state == MAC0) || (r_state == MAC1);
    assign w_x   = w_clr ? (r_i ? r_op[c_IDX_A10] : r_op[c_IDX_A00])
                         : (r_i ? r_op[c_IDX_A11] : r_op[c_IDX_A01]);
    assign w_y   = w_clr ? w_b0j : w_b1j;

    mac16 #(
        .DW    (DW),
        .OUT_W (OUT_W)
    ) u_mac (
        .clk (clk),
        .rst (rst),
        .x   (w_x),
        .y   (w_y),
        .clr (w_clr),
        .en  (w_en),
        .acc (out_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_i     <= 1'b0;
            r_j     <= 2'd0;
            r_idx   <= 3'd0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            for (int n = 0; n < c_NUM_OPS; n++) begin
                r_op[n] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_op[c_IDX_A00] <= a0;
                        r_op[c_IDX_A01] <= a1;
                        r_op[c_IDX_A10] <= a2;
                        r_op[c_IDX_A11] <= a3;
                        r_op[c_IDX_B00] <= b0;
                        r_op[c_IDX_B01] <= b1;
                        r_op[c_IDX_B02] <= b2;
                        r_op[c_IDX_B10] <= b3;
                        r_op[c_IDX_B11] <= b4;
                        r_op[c_IDX_B12] <= b5;
                        r_i     <= 1'b0;
                        r_j     <= 2'd0;
                        r_idx   <= 3'd0;
                        r_busy  <= 1'b1;
                        r_state <= MAC0;
                    end
                end
                MAC0: r_state <= MAC1;
                MAC1: begin
                    r_valid <= 1'b1;
                    r_state <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        r_valid <= 1'b0;
                        if (r_idx == c_LAST_IDX) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            if (r_j == 2'd2) begin
                                r_j <= 2'd0;
                                r_i <= 1'b1;
                            end else begin
                                r_j <= r_j + 2'd1;
                            end
                            r_idx   <= r_idx + 3'd1;
                            r_state <= MAC0;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign out_valid = r_valid;
    assign out_idx   = r_idx;
    assign done      = r_done;

endmodule

`default_nettype wire
